// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream_mux block: mode encodings and default sizing.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_IN = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: the first requester found starting one past ptr_i, with wrap.
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [SEL_W-1:0]  grant_o,
  output logic              grant_vld_o
);

  logic [NUM_IN-1:0] req_rot;
  logic              found;
  int                idx;

  always_comb begin
    grant_o     = '0;
    grant_vld_o = 1'b0;
    found       = 1'b0;
    req_rot     = '0;
    idx         = 0;
    // Offsets 1..NUM_IN put the channel that was granted last at the lowest priority.
    for (int k = 1; k <= NUM_IN; k++) begin
      idx     = (int'(ptr_i) + k) % NUM_IN;
      req_rot = req_i >> idx;
      if (!found && req_rot[0]) begin
        found       = 1'b1;
        grant_o     = SEL_W'(idx);
        grant_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// Round-robin mode exists only when STREAM_MUX_RR_EN is defined; otherwise mode is ignored.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;

  assign load_en = !out_valid_q || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_vld;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .grant_o     (rr_grant),
    .grant_vld_o (rr_vld)
  );

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_vld = rr_vld;
    end else if (int'(sel) < NUM_IN) begin
      grant     = sel;
      grant_vld = 1'b1;
    end
  end

  // Priority only advances on an actual round-robin transfer, never on a stall.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (mode == MODE_RR)) begin
      ptr_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SEL_W'(NUM_IN - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (int'(sel) < NUM_IN) begin
      grant     = sel;
      grant_vld = 1'b1;
    end
  end
`endif

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_vld) begin
      in_ready = NUM_IN'(1) << grant;
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_src_d  = grant;
      end
    end
  end

  // Output stage: data is cleared on reset too, so a stalled word never survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed sequences, a vector table and random traffic.
module tb_stream_mux;

  localparam int N = 4;
  localparam int W = 8;
`ifdef STREAM_MUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [1:0]     sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     out_src;
  logic           out_ready;

  logic [5*W-1:0] in_data5;
  logic [4:0]     in_valid5, in_ready5;
  logic [2:0]     sel5;
  logic           mode5;
  logic [W-1:0]   out_data5;
  logic           out_valid5;
  logic [2:0]     out_src5;
  logic           out_ready5;

  stream_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid), .out_src(out_src),
    .out_ready(out_ready)
  );

  stream_mux #(.WIDTH(W), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .sel(sel5), .mode(mode5), .out_data(out_data5), .out_valid(out_valid5), .out_src(out_src5),
    .out_ready(out_ready5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the word held at the output and the last round-robin winner.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_src   = 0;
  int           m_last  = N - 1;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] valid;
    logic [4:0] exp_ready;
    logic       exp_ov;
  } vec5_t;

  vec5_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Grant chosen by the rules: fixed select, or the valid channel closest after the last winner.
  task automatic model_grant(output int g, output bit gv);
    int best;
    g    = 0;
    gv   = 1'b0;
    best = N;
    if (RR_EN && mode) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          int d;
          d = (i - m_last - 1 + 2 * N) % N;
          if (d < best) begin
            best = d;
            g    = i;
          end
        end
      end
      gv = (best < N);
    end else begin
      g  = int'(sel);
      gv = (g < N);
    end
  endtask

  // Called at a negedge with inputs applied; checks in_ready, clocks once, checks outputs.
  task automatic tick();
    int           g;
    bit           gv, ld, xf;
    logic [N-1:0] er;
    logic [W-1:0] dv;
    #1;
    model_grant(g, gv);
    ld = !m_valid || out_ready;
    er = (rst_n && ld && gv) ? N'(1 << g) : '0;
    xf = |(er & in_valid);
    dv = in_data[g*W +: W];
    check("in_ready", in_ready, er);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_last  = N - 1;
    end else if (ld) begin
      m_valid = xf;
      if (xf) begin
        m_data = dv;
        m_src  = g;
        if (RR_EN && mode) m_last = g;
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_src", out_src, m_src);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{3'd5, 5'b11111, 5'b00000, 1'b0};
    tbl[1] = '{3'd4, 5'b10000, 5'b10000, 1'b1};
    tbl[2] = '{3'd7, 5'b11111, 5'b00000, 1'b0};
    tbl[3] = '{3'd0, 5'b00001, 5'b00001, 1'b1};
    tbl[4] = '{3'd2, 5'b00000, 5'b00100, 1'b0};
    tbl[5] = '{3'd6, 5'b11111, 5'b00000, 1'b0};
    tbl[6] = '{3'd3, 5'b01000, 5'b01000, 1'b1};

    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    sel        = '0;
    mode       = 1'b0;
    out_ready  = 1'b1;
    in_data5   = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    in_valid5  = '0;
    sel5       = '0;
    mode5      = 1'b0;
    out_ready5 = 1'b1;

    @(negedge clk);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_valid5", out_valid5, 0);
    rst_n = 1'b1;

    // Out-of-range select on a 5-channel instance.
    for (int i = 0; i < 7; i++) begin
      sel5      = tbl[i].sel;
      in_valid5 = tbl[i].valid;
      #1;
      check("t5_ready", in_ready5, tbl[i].exp_ready);
      @(posedge clk);
      #1;
      check("t5_out_valid", out_valid5, tbl[i].exp_ov);
      if (tbl[i].exp_ov) begin
        check("t5_out_data", out_data5, 8'(8'h10 + tbl[i].sel));
        check("t5_out_src", out_src5, tbl[i].sel);
      end
      @(negedge clk);
    end
    in_valid5 = '0;

    // Fixed select of channel 2.
    do_reset();
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = 32'h00A5_0000;
    #1;
    check("fix_ready", in_ready, 4'b0100);
    tick();
    check("fix_valid", out_valid, 1);
    check("fix_data", out_data, 8'hA5);
    check("fix_src", out_src, 2);
    in_valid = '0;
    tick();
    check("fix_drain", out_valid, 0);

    // Round-robin from reset with every channel valid.
    do_reset();
    mode     = 1'b1;
    sel      = 2'd0;
    in_valid = 4'b1111;
    in_data  = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_seq_valid", out_valid, 1);
      check("rr_seq_src", out_src, RR_EN ? (k % 4) : 0);
    end

    // Three-cycle stall then release.
    do_reset();
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b1111;
    in_data   = 32'h0000_5A00;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      tick();
      check("stall_data", out_data, 8'h5A);
      check("stall_src", out_src, 1);
      check("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_data   = 32'h0000_C300;
    tick();
    check("release_valid", out_valid, 1);
    check("release_data", out_data, 8'hC3);

    // Wrap from channel 3 back to channel 0, then an idle cycle.
    do_reset();
    mode     = 1'b1;
    sel      = 2'd0;
    in_valid = 4'b1000;
    in_data  = 32'hD4C3_B2A1;
    tick();
    check("wrap_first_valid", out_valid, RR_EN ? 1 : 0);
    in_valid = 4'b1001;
    tick();
    check("wrap_valid", out_valid, 1);
    check("wrap_src", out_src, 0);
    check("wrap_data", out_data, 8'hA1);
    in_valid = 4'b0000;
    tick();
    check("idle_drop", out_valid, 0);

    // Reset during a stall discards the held word and restarts priority at channel 0.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_stall_ready", in_ready, 0);
    tick();
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_data", out_data, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_restart_src", out_src, 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
